// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and access decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // Stores only exist for B/H/W; loads additionally allow BU/HU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic ill;
    ill = 1'b1;
    case (f3)
      F3_B, F3_H, F3_W: ill = 1'b0;
      F3_BU, F3_HU:     ill = we;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic f3_misalign(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = a[0];
      F3_W:        mis = (a != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction: selects the addressed byte/half of the read word and extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  ofs_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = word_i >> {ofs_i, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = ofs_i[1] ? word_i[31:16] : word_i[15:0];
    data_o  = word_i;
    case (func3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data_o = {24'h000000, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_HU:   data_o = {16'h0000, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_data_access.sv
// RV32I load/store unit: one access per request over a req/ack memory port, with error flagging.
// Optional REQ watchdog enabled by defining LSU_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for LSUstart; request fields latched on accept
// REQ     | MEMreq held with a stable bus until MEMack (or watchdog expiry)
// DONE    | one-cycle LSUdone pulse with flags and load data
module lsu_data_access
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        LSUstart,
  input  logic        LSUwe,
  input  logic [2:0]  LSUfunc3,
  input  logic [31:0] LSUaddr,
  input  logic [31:0] LSUwdata,
  output logic        LSUbusy,
  output logic        LSUdone,
  output logic [31:0] LSUrdata,
  output logic        LSUmisalign,
  output logic        LSUillegal,
  output logic        LSUtimeout,
  output logic        MEMreq,
  output logic        MEMwe,
  output logic [31:0] MEMaddr,
  output logic [3:0]  MEMbe,
  output logic [31:0] MEMwdata,
  input  logic        MEMack,
  input  logic [31:0] MEMrdata
);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        mis_q, ill_q, to_q;
  logic [31:0] rdata_q;

  logic        ill_in, mis_in, accept, go_req, in_req, timeout_hit;
  logic [3:0]  be;
  logic [31:0] wd_rep;
  logic [31:0] load_data;

  // Illegal takes priority, so misalign is only reported for legal encodings.
  assign ill_in = f3_illegal(LSUwe, LSUfunc3);
  assign mis_in = !ill_in && f3_misalign(LSUfunc3, LSUaddr[1:0]);
  assign accept = (state_q == ST_IDLE) && LSUstart;
  assign go_req = accept && !ill_in && !mis_in;
  assign in_req = (state_q == ST_REQ);

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_hit = in_req && !MEMack && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (go_req) begin
      cnt_d = CW'(TIMEOUT_CYCLES - 1);
    end else if (in_req && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (LSUstart) state_d = (ill_in || mis_in) ? ST_DONE : ST_REQ;
      ST_REQ:  if (MEMack || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= LSUwe;
        f3_q    <= LSUfunc3;
        addr_q  <= LSUaddr;
        wdata_q <= LSUwdata;
        mis_q   <= mis_in;
        ill_q   <= ill_in;
        to_q    <= 1'b0;
      end
      if (timeout_hit) to_q <= 1'b1;
      if (in_req && MEMack && !we_q) rdata_q <= load_data;
    end
  end

  lsu_load_align u_align (
    .word_i  (MEMrdata),
    .ofs_i   (addr_q[1:0]),
    .func3_i (f3_q),
    .data_o  (load_data)
  );

  // f3[1:0] is shared between signed and unsigned loads, so BU/HU get the B/H enables.
  always_comb begin
    be     = 4'b1111;
    wd_rep = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be     = 4'b0001 << addr_q[1:0];
        wd_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = 4'b0011 << {addr_q[1], 1'b0};
        wd_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wd_rep = wdata_q;
      end
    endcase
  end

  assign MEMreq      = in_req;
  assign MEMwe       = in_req && we_q;
  assign MEMaddr     = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign MEMbe       = in_req ? be : 4'b0000;
  assign MEMwdata    = in_req ? wd_rep : 32'h0;

  assign LSUbusy     = (state_q != ST_IDLE);
  assign LSUdone     = (state_q == ST_DONE);
  assign LSUrdata    = rdata_q;
  assign LSUmisalign = LSUdone && mis_q;
  assign LSUillegal  = LSUdone && ill_q;
  assign LSUtimeout  = LSUdone && to_q;

endmodule
